icmp_echo_resp: RTL

ICMP_ECHO_RESP -- requirements
Module: icmp_echo_resp

---
 rtl/icmp_echo_resp.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/icmp_echo_resp.sv
// ICMP echo responder: turns matching echo requests into echo replies (swapped
// addresses, incrementally updated checksum) and buffers the payload in a FIFO.

module icmp_echo_axis_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_s_tdata,
    input  logic [KEEP_WIDTH-1:0] i_s_tkeep,
    input  logic                  i_s_tvalid,
    output logic                  o_s_tready,
    input  logic                  i_s_tlast,
    input  logic                  i_s_tuser,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic [KEEP_WIDTH-1:0] o_m_tkeep,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    output logic                  o_m_tlast,
    output logic                  o_m_tuser
);
    localparam int W  = DATA_WIDTH + KEEP_WIDTH + 2;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_s_tready = (r_count != (AW+1)'(DEPTH));
    assign o_m_tvalid = (r_count != '0);
    assign w_wr       = i_s_tvalid && o_s_tready;
    assign w_rd       = o_m_tvalid && i_m_tready;
    assign {o_m_tuser, o_m_tlast, o_m_tkeep, o_m_tdata} = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {i_s_tuser, i_s_tlast, i_s_tkeep, i_s_tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module icmp_echo_resp #(
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH     = 8192,
    parameter int HOLDOFF_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_icmp_hdr_valid,
    output logic                  s_icmp_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [31:0]           s_ip_source_ip,
    input  logic [31:0]           s_ip_dest_ip,
    input  logic [7:0]            s_ip_ttl,
    input  logic [7:0]            s_icmp_type,
    input  logic [7:0]            s_icmp_code,
    input  logic [15:0]           s_icmp_checksum,
    input  logic [31:0]           s_icmp_header,
    input  logic [15:0]           s_icmp_length,
    output logic                  m_icmp_hdr_valid,
    input  logic                  m_icmp_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [31:0]           m_ip_source_ip,
    output logic [31:0]           m_ip_dest_ip,
    output logic [7:0]            m_ip_ttl,
    output logic [7:0]            m_icmp_type,
    output logic [7:0]            m_icmp_code,
    output logic [15:0]           m_icmp_checksum,
    output logic [31:0]           m_icmp_header,
    output logic [15:0]           m_icmp_length,
    input  logic [DATA_WIDTH-1:0] s_icmp_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_icmp_payload_axis_tkeep,
    input  logic                  s_icmp_payload_axis_tvalid,
    output logic                  s_icmp_payload_axis_tready,
    input  logic                  s_icmp_payload_axis_tlast,
    input  logic                  s_icmp_payload_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_icmp_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_icmp_payload_axis_tkeep,
    output logic                  m_icmp_payload_axis_tvalid,
    input  logic                  m_icmp_payload_axis_tready,
    output logic                  m_icmp_payload_axis_tlast,
    output logic                  m_icmp_payload_axis_tuser,
    output logic [31:0]           echo_count,
    output logic [31:0]           drop_count,
    output logic [1:0]            o_dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and data stays stable while valid is held.
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DROP} state_t;

    state_t      r_state, w_next_state;
    logic        r_hdr_valid;
    logic        r_pay_done;
    logic [31:0] r_holdoff;
    logic [31:0] r_echo_count;
    logic [31:0] r_drop_count;
    logic        w_hdr_acc, w_match, w_in_last, w_out_hs;
    logic        w_to_fifo, w_fifo_s_ready, w_echo_done, w_drop;
    logic        w_unused_ttl;

    // Reply checksum: only the type byte changes 8->0, so ~(~C + ~0x0800).
    function automatic logic [15:0] echo_csum(input logic [15:0] c);
        logic [16:0] s;
        s = {1'b0, ~c} + 17'h0F7FF;
        return ~(s[15:0] + {15'd0, s[16]});
    endfunction

    assign w_unused_ttl     = ^s_ip_ttl;
    assign s_icmp_hdr_ready = (r_state == ST_IDLE) && !rst;
    assign w_hdr_acc        = s_icmp_hdr_valid && s_icmp_hdr_ready;
    assign w_match          = (s_icmp_type == 8'd8) && (s_icmp_code == 8'd0) &&
                              ({16'd0, s_icmp_length} <= 32'(FIFO_DEPTH)) && (r_holdoff == '0);
    assign w_in_last        = s_icmp_payload_axis_tvalid && s_icmp_payload_axis_tready &&
                              s_icmp_payload_axis_tlast;
    assign w_out_hs         = r_hdr_valid && m_icmp_hdr_ready;
    assign w_to_fifo        = ((r_state == ST_HDR) && !r_pay_done) || (r_state == ST_PAYLOAD);
    assign m_icmp_hdr_valid = r_hdr_valid;
    assign echo_count       = r_echo_count;
    assign drop_count       = r_drop_count;
    assign o_dbg_state      = r_state;

    always_comb begin
        w_next_state = r_state;
        w_echo_done  = 1'b0;
        w_drop       = 1'b0;
        s_icmp_payload_axis_tready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_acc) begin
                    w_next_state = w_match ? ST_HDR : ST_DROP;
                    w_drop       = !w_match;
                end
            end
            ST_HDR: begin
                s_icmp_payload_axis_tready = w_fifo_s_ready && !r_pay_done;
                if (w_out_hs && (r_pay_done || w_in_last)) begin
                    w_next_state = ST_IDLE;
                    w_echo_done  = 1'b1;
                end else if (w_out_hs) begin
                    w_next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                s_icmp_payload_axis_tready = w_fifo_s_ready;
                if (w_in_last) begin
                    w_next_state = ST_IDLE;
                    w_echo_done  = 1'b1;
                end
            end
            default: begin
                s_icmp_payload_axis_tready = 1'b1;
                if (w_in_last) w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hdr_valid  <= 1'b0;
            r_pay_done   <= 1'b0;
            r_holdoff    <= '0;
            r_echo_count <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_hdr_acc && w_match)  r_hdr_valid <= 1'b1;
            else if (w_out_hs)         r_hdr_valid <= 1'b0;
            if ((r_state == ST_IDLE) || (w_next_state == ST_IDLE)) r_pay_done <= 1'b0;
            else if (w_in_last)                                   r_pay_done <= 1'b1;
            if (w_hdr_acc && w_match && (HOLDOFF_CYCLES != 0)) r_holdoff <= 32'(HOLDOFF_CYCLES);
            else if (r_holdoff != '0)                          r_holdoff <= r_holdoff - 1'b1;
            if (w_echo_done && (r_echo_count != 32'hFFFF_FFFF)) r_echo_count <= r_echo_count + 1'b1;
            if (w_drop && (r_drop_count != 32'hFFFF_FFFF))      r_drop_count <= r_drop_count + 1'b1;
        end
    end

    // Fields are only captured in IDLE, so they stay stable while the reply is pending.
    always_ff @(posedge clk) begin
        if (w_hdr_acc) begin
            m_eth_dest_mac  <= s_eth_src_mac;
            m_eth_src_mac   <= s_eth_dest_mac;
            m_ip_source_ip  <= s_ip_dest_ip;
            m_ip_dest_ip    <= s_ip_source_ip;
            m_ip_ttl        <= 8'd64;
            m_icmp_type     <= 8'd0;
            m_icmp_code     <= 8'd0;
            m_icmp_checksum <= echo_csum(s_icmp_checksum);
            m_icmp_header   <= s_icmp_header;
            m_icmp_length   <= s_icmp_length;
        end
    end

    icmp_echo_axis_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .DEPTH      (FIFO_DEPTH / KEEP_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_s_tdata  (s_icmp_payload_axis_tdata),
        .i_s_tkeep  (s_icmp_payload_axis_tkeep),
        .i_s_tvalid (s_icmp_payload_axis_tvalid && w_to_fifo),
        .o_s_tready (w_fifo_s_ready),
        .i_s_tlast  (s_icmp_payload_axis_tlast),
        .i_s_tuser  (s_icmp_payload_axis_tuser),
        .o_m_tdata  (m_icmp_payload_axis_tdata),
        .o_m_tkeep  (m_icmp_payload_axis_tkeep),
        .o_m_tvalid (m_icmp_payload_axis_tvalid),
        .i_m_tready (m_icmp_payload_axis_tready),
        .o_m_tlast  (m_icmp_payload_axis_tlast),
        .o_m_tuser  (m_icmp_payload_axis_tuser)
    );
endmodule
